// File: rtl/instruction_execute_pkg.sv
// Shared encodings and payload types for the EX stage (ALU codes, operand/destination
// selects, forwarding selects, multiplier FSM states, EX/MEM control payload).
package instruction_execute_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;
  localparam logic [3:0] ALU_SRLV = 4'd12;
  localparam logic [3:0] ALU_SRAV = 4'd13;
  localparam logic [3:0] ALU_LUI  = 4'd14;
  localparam logic [3:0] ALU_MUL  = 4'd15;

  // B-operand select
  localparam logic [1:0] SRC_IMM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  // Destination select; 11 is illegal and suppresses the register write
  localparam logic [1:0] DST_RD      = 2'b01;
  localparam logic [1:0] DST_R31     = 2'b10;
  localparam logic [1:0] DST_ILLEGAL = 2'b11;

  // Forwarding select; 00 and 11 both take the ID/EX value
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_RUN  = 2'b01,
    MS_DONE = 2'b10
  } mul_state_e;

  // Controls carried through EX/MEM; all-zero is a bubble
  typedef struct packed {
    logic [1:0] width;
    logic       sign_flag;
    logic       mem2reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src;
    logic       jump;
  } exmem_ctrl_t;

endpackage

// File: rtl/instruction_execute_alu.sv
// Combinational ALU: (A, B, shamt, op) -> result. Shifts act on B; variable shifts
// take the amount from A[4:0]. MUL is produced by the stage's multiplier, so it yields 0 here.
module instruction_execute_alu
  import instruction_execute_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_OP   = 4
) (
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [4:0]         shamt_i,
  input  logic [NB_OP-1:0]   op_i,
  output logic [NB_DATA-1:0] result_o
);

  // Operation select
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = NB_DATA'($signed(a_i) < $signed(b_i));
      ALU_SLTU: result_o = NB_DATA'(a_i < b_i);
      ALU_SLL:  result_o = b_i << shamt_i;
      ALU_SRL:  result_o = b_i >> shamt_i;
      ALU_SRA:  result_o = NB_DATA'($signed(b_i) >>> shamt_i);
      ALU_SLLV: result_o = b_i << a_i[4:0];
      ALU_SRLV: result_o = b_i >> a_i[4:0];
      ALU_SRAV: result_o = NB_DATA'($signed(b_i) >>> a_i[4:0]);
      ALU_LUI:  result_o = b_i << 16;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/instruction_execute.sv
// MIPS EX stage: forwarding muxes, ALU, destination select and the EX/MEM register.
// Optional iterative multiplier enabled by defining EX_MUL_EN; without it, ALU code 15
// returns 0 with the register write suppressed and o_busy is tied low.
module instruction_execute
  import instruction_execute_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 5,
  parameter int unsigned NB_OP   = 4
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [4:0]         i_shamt,
  input  logic [NB_DATA-1:0] i_pc_link,
  input  logic [NB_ADDR-1:0] i_rt,
  input  logic [NB_ADDR-1:0] i_rd,
  input  logic [1:0]         i_regDst,
  input  logic [NB_OP-1:0]   i_aluOP,
  input  logic [1:0]         i_aluSrc,
  input  logic [1:0]         i_fwdA,
  input  logic [1:0]         i_fwdB,
  input  logic [NB_DATA-1:0] i_fwd_mem,
  input  logic [NB_DATA-1:0] i_fwd_wb,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic               i_mem2reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic               i_jump,
  output logic [NB_DATA-1:0] o_result,
  output logic [NB_DATA-1:0] o_data4Mem,
  output logic [NB_ADDR-1:0] o_write_reg,
  output logic [1:0]         o_width,
  output logic               o_sign_flag,
  output logic               o_mem2reg,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_regWrite,
  output logic [1:0]         o_aluSrc,
  output logic               o_jump,
  output logic               o_busy
);

  logic [NB_DATA-1:0] op_a;
  logic [NB_DATA-1:0] rt_fwd;
  logic [NB_DATA-1:0] op_b;
  logic [NB_DATA-1:0] alu_res;
  logic [NB_DATA-1:0] ex_result;
  logic [NB_ADDR-1:0] dst_reg;
  logic               dst_legal;
  logic               mul_req;
  logic               reg_write_c;
  logic               mul_busy;
  logic               mul_done;
  logic [NB_DATA-1:0] mul_prod;

  exmem_ctrl_t        ctrl_in;
  exmem_ctrl_t        ctrl_d;
  exmem_ctrl_t        ctrl_q;
  logic [NB_DATA-1:0] result_d;
  logic [NB_DATA-1:0] result_q;
  logic [NB_DATA-1:0] data4mem_d;
  logic [NB_DATA-1:0] data4mem_q;
  logic [NB_ADDR-1:0] write_reg_d;
  logic [NB_ADDR-1:0] write_reg_q;

  // Forwarding muxes and B-operand select
  always_comb begin
    op_a   = i_rs_data;
    rt_fwd = i_rt_data;
    case (i_fwdA)
      FWD_MEM: op_a = i_fwd_mem;
      FWD_WB:  op_a = i_fwd_wb;
      default: op_a = i_rs_data;
    endcase
    case (i_fwdB)
      FWD_MEM: rt_fwd = i_fwd_mem;
      FWD_WB:  rt_fwd = i_fwd_wb;
      default: rt_fwd = i_rt_data;
    endcase
    op_b = (i_aluSrc == SRC_IMM) ? i_imm : rt_fwd;
  end

  // Destination register select
  always_comb begin
    dst_reg   = i_rt;
    dst_legal = 1'b1;
    case (i_regDst)
      DST_RD:      dst_reg = i_rd;
      DST_R31:     dst_reg = NB_ADDR'(31);
      DST_ILLEGAL: dst_legal = 1'b0;
      default:     dst_reg = i_rt;
    endcase
  end

  instruction_execute_alu #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .shamt_i  (i_shamt),
    .op_i     (i_aluOP),
    .result_o (alu_res)
  );

  // Link select overrides the ALU, so it also takes precedence over a MUL code
  assign mul_req   = (i_aluOP == NB_OP'(ALU_MUL)) && (i_aluSrc != SRC_LINK);
  assign ex_result = (i_aluSrc == SRC_LINK) ? i_pc_link : alu_res;

`ifdef EX_MUL_EN
  mul_state_e         state_q;
  logic [4:0]         count_q;
  logic [NB_DATA-1:0] mcand_q;
  logic [NB_DATA-1:0] mplier_q;
  logic [NB_DATA-1:0] prod_q;

  // Busy is raised in the accepting cycle so upstream holds ID/EX from the start
  assign mul_busy    = ((state_q == MS_IDLE) && mul_req && !i_halt) || (state_q == MS_RUN);
  assign mul_done    = (state_q == MS_DONE);
  assign mul_prod    = prod_q;
  assign reg_write_c = i_regWrite && dst_legal;

  // Shift-add multiplier: one multiplier bit per RUN cycle, low word only
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= MS_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (!i_halt) begin
      case (state_q)
        MS_IDLE: begin
          if (mul_req) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            prod_q   <= '0;
            count_q  <= '0;
            state_q  <= MS_RUN;
          end
        end
        MS_RUN: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 5'd1;
          // all-ones count marks the 32nd iteration
          if (&count_q) state_q <= MS_DONE;
        end
        MS_DONE: state_q <= MS_IDLE;
        default: state_q <= MS_IDLE;
      endcase
    end
  end
`else
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_prod    = '0;
  assign reg_write_c = i_regWrite && dst_legal && !mul_req;
`endif

  assign o_busy = mul_busy;

  // Controls presented for loading into EX/MEM
  always_comb begin
    ctrl_in           = '0;
    ctrl_in.width     = i_width;
    ctrl_in.sign_flag = i_sign_flag;
    ctrl_in.mem2reg   = i_mem2reg;
    ctrl_in.mem_read  = i_memRead;
    ctrl_in.mem_write = i_memWrite;
    ctrl_in.reg_write = reg_write_c;
    ctrl_in.alu_src   = i_aluSrc;
    ctrl_in.jump      = i_jump;
  end

  // EX/MEM next state: halt holds, busy or stall inserts a bubble, otherwise load
  always_comb begin
    ctrl_d      = ctrl_q;
    result_d    = result_q;
    data4mem_d  = data4mem_q;
    write_reg_d = write_reg_q;
    if (!i_halt) begin
      if (mul_busy || (i_stall && !mul_done)) begin
        ctrl_d = '0;
      end else begin
        ctrl_d      = ctrl_in;
        result_d    = mul_done ? mul_prod : ex_result;
        data4mem_d  = rt_fwd;
        write_reg_d = dst_reg;
      end
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q      <= '0;
      result_q    <= '0;
      data4mem_q  <= '0;
      write_reg_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      data4mem_q  <= data4mem_d;
      write_reg_q <= write_reg_d;
    end
  end

  assign o_result    = result_q;
  assign o_data4Mem  = data4mem_q;
  assign o_write_reg = write_reg_q;
  assign o_width     = ctrl_q.width;
  assign o_sign_flag = ctrl_q.sign_flag;
  assign o_mem2reg   = ctrl_q.mem2reg;
  assign o_memRead   = ctrl_q.mem_read;
  assign o_memWrite  = ctrl_q.mem_write;
  assign o_regWrite  = ctrl_q.reg_write;
  assign o_aluSrc    = ctrl_q.alu_src;
  assign o_jump      = ctrl_q.jump;

endmodule
